// File: rtl/tpu_pkg.sv
// Shared widths, address map and lane-select encodings for the operand storage stage.
package tpu_pkg;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 3;
    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int NUM_LANES = 4;

    localparam logic [ADDR_W-1:0] ADDR_W0 = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_W1 = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_W2 = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_W3 = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_X0 = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_X1 = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_X2 = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_X3 = 3'd7;

    localparam logic [1:0] SEL_0   = 2'd0;
    localparam logic [1:0] SEL_1   = 2'd1;
    localparam logic [1:0] SEL_OFF = 2'd2;

    // Slot maps per lane, index order {b1, b0, a1, a0}; only the B lanes swap X1/X2 in transpose.
    localparam logic [NUM_LANES-1:0][ADDR_W-1:0] LANE_N0 = {ADDR_X2, ADDR_X0, ADDR_W2, ADDR_W0};
    localparam logic [NUM_LANES-1:0][ADDR_W-1:0] LANE_N1 = {ADDR_X3, ADDR_X1, ADDR_W3, ADDR_W1};
    localparam logic [NUM_LANES-1:0][ADDR_W-1:0] LANE_T0 = {ADDR_X1, ADDR_X0, ADDR_W2, ADDR_W0};
    localparam logic [NUM_LANES-1:0][ADDR_W-1:0] LANE_T1 = {ADDR_X3, ADDR_X2, ADDR_W3, ADDR_W1};
endpackage

// File: rtl/operand_buffer_if.sv
// Host/control-unit bus into the operand buffer and its operand/status outputs.
interface operand_buffer_if;
    import tpu_pkg::*;

    logic                     load_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        in_data;
    logic                     data_valid;
    logic [1:0]               a0_sel;
    logic [1:0]               a1_sel;
    logic [1:0]               b0_sel;
    logic [1:0]               b1_sel;
    logic                     transpose;
    logic signed [DATA_W-1:0] a0;
    logic signed [DATA_W-1:0] a1;
    logic signed [DATA_W-1:0] b0;
    logic signed [DATA_W-1:0] b1;
    logic                     tr_active;
    logic [DEPTH-1:0]         valid_mask;
    logic                     set_loaded;
    logic                     seq_err;

    modport master (
        output load_en, mem_addr, in_data, data_valid,
        output a0_sel, a1_sel, b0_sel, b1_sel, transpose,
        input  a0, a1, b0, b1, tr_active, valid_mask, set_loaded, seq_err
    );

    modport slave (
        input  load_en, mem_addr, in_data, data_valid,
        input  a0_sel, a1_sel, b0_sel, b1_sel, transpose,
        output a0, a1, b0, b1, tr_active, valid_mask, set_loaded, seq_err
    );
endinterface

// File: rtl/operand_buffer_lane_mux.sv
// Combinational operand-lane select: picks one of two slots (transpose-aware) with
// a same-cycle write bypass, or zero when the lane is off or data is not valid.
module operand_lane_mux
    import tpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLOT_N0 = ADDR_W0,
    parameter logic [ADDR_W-1:0] SLOT_N1 = ADDR_W1,
    parameter logic [ADDR_W-1:0] SLOT_T0 = ADDR_W0,
    parameter logic [ADDR_W-1:0] SLOT_T1 = ADDR_W1
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] i_mem,
    input  logic [1:0]                   i_sel,
    input  logic                         i_tr,
    input  logic                         i_data_valid,
    input  logic                         i_load_en,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic [DATA_W-1:0]            i_data,
    output logic [DATA_W-1:0]            o_lane
);
    logic [ADDR_W-1:0] w_slot;

    always_comb begin
        w_slot = i_tr ? SLOT_T0 : SLOT_N0;
        o_lane = '0;
        if (i_sel == SEL_1) begin
            w_slot = i_tr ? SLOT_T1 : SLOT_N1;
        end
        if (i_data_valid && (i_sel == SEL_0 || i_sel == SEL_1)) begin
            // A write landing on the selected slot this cycle wins over the stored byte.
            if (i_load_en && i_addr == w_slot) begin
                o_lane = i_data;
            end else begin
                o_lane = i_mem[w_slot];
            end
        end
    end
endmodule

// File: rtl/operand_buffer.sv
// Operand register file for one 2x2 matmul: stores W0..W3/X0..X3, drives four
// registered operand lanes, and tracks load progress and sequencing errors.
module operand_buffer
    import tpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    operand_buffer_if.slave  bus
);
    logic [DEPTH-1:0][DATA_W-1:0]     r_mem;
    logic [NUM_LANES-1:0][DATA_W-1:0] r_lane;
    logic                             r_tr_active;
    logic [DEPTH-1:0]                 r_valid_mask;
    logic                             r_set_loaded;
    logic                             r_seq_err;
    logic [ADDR_W-1:0]                r_exp_addr;

    logic [NUM_LANES-1:0][1:0]        w_sel;
    logic [NUM_LANES-1:0][DATA_W-1:0] w_lane;

    assign w_sel = {bus.b1_sel, bus.b0_sel, bus.a1_sel, bus.a0_sel};

    // Lanes mux with the pre-update tr_active, so an address-0 write affects the next set only.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        operand_lane_mux #(
            .SLOT_N0 (LANE_N0[gi]),
            .SLOT_N1 (LANE_N1[gi]),
            .SLOT_T0 (LANE_T0[gi]),
            .SLOT_T1 (LANE_T1[gi])
        ) u_mux (
            .i_mem        (r_mem),
            .i_sel        (w_sel[gi]),
            .i_tr         (r_tr_active),
            .i_data_valid (bus.data_valid),
            .i_load_en    (bus.load_en),
            .i_addr       (bus.mem_addr),
            .i_data       (bus.in_data),
            .o_lane       (w_lane[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem        <= '0;
            r_lane       <= '0;
            r_tr_active  <= 1'b0;
            r_valid_mask <= '0;
            r_set_loaded <= 1'b0;
            r_seq_err    <= 1'b0;
            r_exp_addr   <= '0;
        end else begin
            r_lane       <= w_lane;
            r_set_loaded <= 1'b0;
            if (bus.load_en) begin
                r_mem[bus.mem_addr] <= bus.in_data;
                r_exp_addr          <= bus.mem_addr + ADDR_W'(1);
                if (bus.mem_addr != r_exp_addr) begin
                    r_seq_err <= 1'b1;
                end
                if (bus.mem_addr == ADDR_W0) begin
                    r_tr_active  <= bus.transpose;
                    r_valid_mask <= DEPTH'(1);
                end else begin
                    r_valid_mask[bus.mem_addr] <= 1'b1;
                end
                if (bus.mem_addr == ADDR_X3) begin
                    r_set_loaded <= 1'b1;
                end
            end
        end
    end

    assign bus.a0         = $signed(r_lane[0]);
    assign bus.a1         = $signed(r_lane[1]);
    assign bus.b0         = $signed(r_lane[2]);
    assign bus.b1         = $signed(r_lane[3]);
    assign bus.tr_active  = r_tr_active;
    assign bus.valid_mask = r_valid_mask;
    assign bus.set_loaded = r_set_loaded;
    assign bus.seq_err    = r_seq_err;
endmodule
